// File: rtl/escalonador_proc.sv
// Round-robin process scheduler: picks the next ready user process, handshakes
// context switches with the OS and enforces a per-process time quantum.
module escalonador_proc (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [2:0] proc_pronto,
    input  logic [7:0] quantum,
    input  logic       fim_proc,
    input  logic       troca_ok,
    output logic [1:0] id_proc,
    output logic [1:0] id_prox,
    output logic       req_troca,
    output logic       motivo,
    output logic [7:0] cont_quantum
);

    localparam int unsigned ID_W  = 2;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [2:0] {
        S_SO,
        S_SEL,
        S_CARREGA,
        S_EXEC,
        S_SALVA
    } state_t;

    state_t          state;
    logic [ID_W-1:0] ult;
    logic [ID_W-1:0] pick_c;
    logic [CNT_W:0]  quantum_eff_c;
    logic            expira_c;

    // Round-robin search ult+1, ult+2, ult+3 over {1,2,3}; the nearest hit wins.
    always_comb begin
        logic [2:0] cand;
        pick_c = '0;
        cand   = '0;
        for (int k = 3; k >= 1; k--) begin
            cand = 3'(ult) + 3'(k);
            if (cand > 3'd3) begin
                cand = cand - 3'd3;
            end
            if (proc_pronto[2'(cand - 3'd1)]) begin
                pick_c = ID_W'(cand);
            end
        end
    end

    // A zero quantum behaves as a one-cycle slice; compare in 9 bits.
    always_comb begin
        quantum_eff_c = (quantum == '0) ? (CNT_W+1)'(1) : {1'b0, quantum};
        expira_c      = enable && (({1'b0, cont_quantum} + (CNT_W+1)'(1)) >= quantum_eff_c);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= S_SO;
            id_proc      <= '0;
            id_prox      <= '0;
            req_troca    <= 1'b0;
            motivo       <= 1'b0;
            cont_quantum <= '0;
            ult          <= ID_W'(3);
        end else begin
            unique case (state)
                S_SO: begin
                    id_proc   <= '0;
                    req_troca <= 1'b0;
                    if (proc_pronto != '0) begin
                        state <= S_SEL;
                    end
                end
                S_SEL: begin
                    if (proc_pronto != '0) begin
                        id_prox   <= pick_c;
                        req_troca <= 1'b1;
                        state     <= S_CARREGA;
                    end else begin
                        state <= S_SO;
                    end
                end
                S_CARREGA: begin
                    if (troca_ok) begin
                        state        <= S_EXEC;
                        id_proc      <= id_prox;
                        ult          <= id_prox;
                        cont_quantum <= '0;
                        req_troca    <= 1'b0;
                    end
                end
                S_EXEC: begin
                    // A yield outranks a simultaneous quantum expiry.
                    if (fim_proc) begin
                        state     <= S_SALVA;
                        motivo    <= 1'b1;
                        req_troca <= 1'b1;
                    end else if (expira_c) begin
                        state     <= S_SALVA;
                        motivo    <= 1'b0;
                        req_troca <= 1'b1;
                    end else if (enable) begin
                        cont_quantum <= (cont_quantum == '1) ? cont_quantum
                                                             : cont_quantum + CNT_W'(1);
                    end
                end
                S_SALVA: begin
                    if (troca_ok) begin
                        state        <= S_SO;
                        cont_quantum <= '0;
                        req_troca    <= 1'b0;
                        id_proc      <= '0;
                    end
                end
                default: begin
                    state <= S_SO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_escalonador_proc.sv
// Self-checking bench for escalonador_proc: directed scenarios plus randomized
// slices checked against a round-robin / quantum reference model.
module tb_escalonador_proc;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [2:0] proc_pronto = 3'b000;
    logic [7:0] quantum = 8'd4;
    logic       fim_proc = 1'b0;
    logic       troca_ok = 1'b0;
    logic [1:0] id_proc;
    logic [1:0] id_prox;
    logic       req_troca;
    logic       motivo;
    logic [7:0] cont_quantum;

    int n_checks = 0;
    int n_fail   = 0;
    int m_ult    = 3;

    escalonador_proc dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .proc_pronto  (proc_pronto),
        .quantum      (quantum),
        .fim_proc     (fim_proc),
        .troca_ok     (troca_ok),
        .id_proc      (id_proc),
        .id_prox      (id_prox),
        .req_troca    (req_troca),
        .motivo       (motivo),
        .cont_quantum (cont_quantum)
    );

    always #5 clock = ~clock;

    // Reference round-robin: first ready id after ult, cycling 1->2->3->1.
    function automatic int next_pick(input int ult, input logic [2:0] mask);
        int c;
        int r;
        r = 0;
        for (int k = 1; k <= 3; k++) begin
            c = ((ult - 1 + k) % 3) + 1;
            if (r == 0 && mask[c-1] == 1'b1) r = c;
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // From idle: offer mask, expect a switch request after two cycles, then load exp_id.
    task automatic dispatch(input logic [2:0] mask, input int exp_id, input string tag);
        int waited;
        proc_pronto = mask;
        waited = 0;
        while (req_troca !== 1'b1 && waited < 8) begin
            step();
            waited++;
        end
        n_checks++;
        if (waited != 2) begin
            n_fail++;
            $display("FAIL %s latency got %0d cycles exp 2", tag, waited);
        end
        n_checks++;
        if (id_proc !== 2'd0) begin
            n_fail++;
            $display("FAIL %s id_proc in load got %0d exp 0", tag, id_proc);
        end
        n_checks++;
        if (id_prox !== 2'(exp_id)) begin
            n_fail++;
            $display("FAIL %s id_prox got %0d exp %0d", tag, id_prox, exp_id);
        end
        step();
        troca_ok = 1'b1;
        step();
        troca_ok = 1'b0;
        n_checks++;
        if (id_proc !== 2'(exp_id) || req_troca !== 1'b0 || cont_quantum !== 8'd0) begin
            n_fail++;
            $display("FAIL %s run id_proc=%0d req=%0b cnt=%0d exp id=%0d req=0 cnt=0",
                     tag, id_proc, req_troca, cont_quantum, exp_id);
        end
        m_ult = exp_id;
    endtask

    // Finish a pending save and park the scheduler idle.
    task automatic release_proc(input string tag);
        proc_pronto = 3'b000;
        troca_ok = 1'b1;
        step();
        troca_ok = 1'b0;
        n_checks++;
        if (id_proc !== 2'd0 || req_troca !== 1'b0 || cont_quantum !== 8'd0) begin
            n_fail++;
            $display("FAIL %s release id_proc=%0d req=%0b cnt=%0d exp 0/0/0",
                     tag, id_proc, req_troca, cont_quantum);
        end
    endtask

    task automatic yield_proc(input int exp_id, input string tag);
        fim_proc = 1'b1;
        step();
        fim_proc = 1'b0;
        n_checks++;
        if (req_troca !== 1'b1 || motivo !== 1'b1 || id_proc !== 2'(exp_id)) begin
            n_fail++;
            $display("FAIL %s yield req=%0b motivo=%0b id=%0d exp 1/1/%0d",
                     tag, req_troca, motivo, id_proc, exp_id);
        end
        release_proc(tag);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_checks++;
        if (id_proc !== 2'd0 || id_prox !== 2'd0 || req_troca !== 1'b0 ||
            motivo !== 1'b0 || cont_quantum !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_state got id=%0d prox=%0d req=%0b mot=%0b cnt=%0d exp all 0",
                     id_proc, id_prox, req_troca, motivo, cont_quantum);
        end
        reset = 1'b0;
        step();
        m_ult = 3;
    endtask

    task automatic test_first_dispatch();
        enable  = 1'b0;
        quantum = 8'd4;
        dispatch(3'b111, 1, "first_dispatch");
    endtask

    task automatic test_quantum();
        enable = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            n_checks++;
            if (cont_quantum !== 8'(i) || req_troca !== 1'b0) begin
                n_fail++;
                $display("FAIL quantum_count cnt=%0d req=%0b exp cnt=%0d req=0",
                         cont_quantum, req_troca, i);
            end
        end
        step();
        n_checks++;
        if (req_troca !== 1'b1 || motivo !== 1'b0 || id_proc !== 2'd1) begin
            n_fail++;
            $display("FAIL quantum_expiry req=%0b motivo=%0b id=%0d exp 1/0/1",
                     req_troca, motivo, id_proc);
        end
        fim_proc = 1'b1;
        step();
        fim_proc = 1'b0;
        step();
        n_checks++;
        if (req_troca !== 1'b1 || motivo !== 1'b0 || id_proc !== 2'd1) begin
            n_fail++;
            $display("FAIL salva_hold req=%0b motivo=%0b id=%0d exp 1/0/1",
                     req_troca, motivo, id_proc);
        end
        enable = 1'b0;
        release_proc("quantum");
        dispatch(3'b111, 2, "after_quantum");
    endtask

    task automatic test_ignore();
        troca_ok = 1'b1;
        step();
        troca_ok = 1'b0;
        step();
        n_checks++;
        if (id_proc !== 2'd2 || req_troca !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_troca_exec id=%0d req=%0b exp 2/0", id_proc, req_troca);
        end
        yield_proc(2, "ignore");
    endtask

    task automatic test_wrap();
        dispatch(3'b001, 1, "wrap_a");
        yield_proc(1, "wrap_a");
        dispatch(3'b101, 3, "wrap_b");
        yield_proc(3, "wrap_b");
        dispatch(3'b101, 1, "wrap_c");
        yield_proc(1, "wrap_c");
        dispatch(3'b001, 1, "same_id");
        yield_proc(1, "same_id");
    endtask

    task automatic test_fim_expiry();
        quantum = 8'd0;
        enable  = 1'b1;
        dispatch(3'b010, 2, "fim_exp");
        fim_proc = 1'b1;
        step();
        fim_proc = 1'b0;
        n_checks++;
        if (req_troca !== 1'b1 || motivo !== 1'b1 || id_proc !== 2'd2) begin
            n_fail++;
            $display("FAIL fim_and_expiry req=%0b motivo=%0b id=%0d exp 1/1/2",
                     req_troca, motivo, id_proc);
        end
        release_proc("fim_exp");
        dispatch(3'b010, 2, "q_zero");
        step();
        n_checks++;
        if (req_troca !== 1'b1 || motivo !== 1'b0) begin
            n_fail++;
            $display("FAIL quantum_zero req=%0b motivo=%0b exp 1/0", req_troca, motivo);
        end
        release_proc("q_zero");
    endtask

    task automatic test_enable_off();
        quantum = 8'd200;
        enable  = 1'b1;
        dispatch(3'b100, 3, "enable_off");
        step();
        step();
        enable = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step();
            n_checks++;
            if (cont_quantum !== 8'd2 || req_troca !== 1'b0) begin
                n_fail++;
                $display("FAIL frozen_count cycle %0d cnt=%0d req=%0b exp 2/0",
                         i, cont_quantum, req_troca);
            end
        end
        yield_proc(3, "enable_off");
    endtask

    task automatic test_reset_mid();
        proc_pronto = 3'b111;
        step();
        step();
        n_checks++;
        if (req_troca !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_pre req=%0b exp 1", req_troca);
        end
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if (id_proc !== 2'd0 || req_troca !== 1'b0 || id_prox !== 2'd0) begin
            n_fail++;
            $display("FAIL async_reset id=%0d req=%0b prox=%0d exp 0/0/0",
                     id_proc, req_troca, id_prox);
        end
        step();
        reset = 1'b0;
        proc_pronto = 3'b000;
        troca_ok = 1'b1;
        step();
        troca_ok = 1'b0;
        step();
        n_checks++;
        if (id_proc !== 2'd0 || req_troca !== 1'b0 || cont_quantum !== 8'd0) begin
            n_fail++;
            $display("FAIL stray_troca_so id=%0d req=%0b cnt=%0d exp 0/0/0",
                     id_proc, req_troca, cont_quantum);
        end
        m_ult = 3;
        dispatch(3'b111, 1, "post_reset");
        yield_proc(1, "post_reset");
    endtask

    task automatic test_random();
        for (int it = 0; it < 25; it++) begin
            logic [2:0] mask;
            int q, q_eff, f, exp_id, n_seen, n_exp;
            logic mot_exp;
            mask   = 3'($urandom_range(1, 7));
            q      = $urandom_range(0, 10);
            q_eff  = (q == 0) ? 1 : q;
            f      = $urandom_range(1, q_eff + 3);
            exp_id = next_pick(m_ult, mask);
            quantum = 8'(q);
            enable  = 1'b1;
            dispatch(mask, exp_id, "random");
            n_seen = 0;
            for (int n = 1; n <= 40; n++) begin
                if (n == f) fim_proc = 1'b1;
                step();
                fim_proc = 1'b0;
                if (req_troca === 1'b1) begin
                    n_seen = n;
                    break;
                end
            end
            n_exp   = (f <= q_eff) ? f : q_eff;
            mot_exp = (f <= q_eff);
            n_checks++;
            if (n_seen != n_exp || motivo !== mot_exp || id_proc !== 2'(exp_id)) begin
                n_fail++;
                $display("FAIL random_slice it %0d cycles=%0d motivo=%0b id=%0d exp %0d/%0b/%0d (q=%0d f=%0d)",
                         it, n_seen, motivo, id_proc, n_exp, mot_exp, exp_id, q, f);
            end
            release_proc("random");
        end
    endtask

    initial begin
        test_reset();
        test_first_dispatch();
        test_quantum();
        test_ignore();
        test_wrap();
        test_fim_expiry();
        test_enable_off();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/escalonador_proc.md
ESCALONADOR_PROC -- requirements
Module: escalonador_proc

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clock  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; forces reset state immediately.
REQ-004 enable  input  1  preemption enable; 1 = quantum expiry preempts user process.
REQ-005 proc_pronto  input  3  ready mask; bit k = user process k+1 ready.
REQ-006 quantum  input  8  time slice in cycles; 0 treated as 1.
REQ-007 fim_proc  input  1  single-cycle pulse: running user process terminated or yielded.
REQ-008 troca_ok  input  1  single-cycle pulse from OS: context save/restore finished.
REQ-009 id_proc  output  2  partition selector for the address offset adder; 0 = OS, 1..3 = user process.
REQ-010 id_prox  output  2  registered next process chosen by round-robin.
REQ-011 req_troca  output  1  level request to OS for context switch.
REQ-012 motivo  output  1  switch cause: 0 = quantum expiry, 1 = fim_proc.
REQ-013 cont_quantum  output  8  cycles elapsed in current slice.

Function
REQ-014 States SHALL be S_SO, S_SEL, S_CARREGA, S_EXEC, S_SALVA, encoded in a registered state variable.
REQ-015 S_SO: id_proc=0, req_troca=0; next S_SEL when proc_pronto!=0, else stay.
REQ-016 S_SEL (exactly one cycle): id_prox <= first ready process searching ult+1, ult+2, ult+3 modulo the set {1,2,3} (3 wraps to 1, id 0 never chosen); next S_CARREGA; if proc_pronto==0 in this cycle, id_prox unchanged and next S_SO.
REQ-017 S_CARREGA: id_proc=0, req_troca=1, motivo holds; on troca_ok -> S_EXEC, id_proc<=id_prox, ult<=id_prox, cont_quantum<=0.
REQ-018 S_EXEC: id_proc=current process, req_troca=0; cont_quantum increments by 1 per cycle while enable=1, holds while enable=0.
REQ-019 Quantum expiry SHALL be enable=1 and cont_quantum+1 >= max(quantum,1) (9-bit compare, no overflow); -> S_SALVA with motivo<=0.
REQ-020 fim_proc in S_EXEC -> S_SALVA with motivo<=1, independent of enable; fim_proc together with expiry: motivo=1.
REQ-021 S_SALVA: id_proc holds the preempted process id, req_troca=1; on troca_ok -> S_SO, cont_quantum<=0.
REQ-022 troca_ok outside S_CARREGA/S_SALVA and fim_proc outside S_EXEC SHALL be ignored.
REQ-023 cont_quantum SHALL saturate at 255 and never wrap.
REQ-024 A sole ready process equal to ult SHALL be reselected (same id re-dispatched).
REQ-025 quantum and proc_pronto SHALL be sampled live each cycle; changes mid-slice take effect next cycle.
REQ-026 Minimum dispatch latency from S_SO with ready process to id_proc!=0: 2 cycles plus troca_ok wait.

Reset
REQ-027 Reset SHALL force state=S_SO, id_proc=0, id_prox=0, req_troca=0, motivo=0, cont_quantum=0, ult=3 (first pick is process 1).
REQ-028 Reset asserted in any state, including mid-handshake, SHALL abort the switch; a later troca_ok is ignored in S_SO.

Verification
REQ-029 Reset, proc_pronto=3'b111, troca_ok 1 cycle after req_troca -> id_proc sequence 0,1 and ult=1.
REQ-030 quantum=4, enable=1, process 1 running -> cont_quantum 0,1,2,3, then S_SALVA, motivo=0, req_troca=1, id_proc=1 until troca_ok; next dispatch id_prox=2.
REQ-031 proc_pronto=3'b101, ult=1 -> id_prox=3; then ult=3 -> id_prox=1 (wrap, skip 0 and 2).
REQ-032 fim_proc and expiry same cycle, quantum=0 -> S_SALVA after 1 cycle, motivo=1.
REQ-033 enable=0 in S_EXEC for 300 cycles -> cont_quantum frozen, no preemption; fim_proc still yields S_SALVA.
REQ-034 reset during S_CARREGA with req_troca=1 -> id_proc=0, req_troca=0 immediately; stray troca_ok afterwards -> no state change.
